// File: rtl/julia_stripe_engine.sv
// Escape-time fractal engine for one rectangular stripe of the frame (Julia or Mandelbrot).
// Iterates one z-update per cycle and emits one colour index per pixel on a valid/ready port.
module julia_stripe_engine #(
   parameter int INT_BITS  = 4,
   parameter int FRAC_BITS = 33,
   parameter int MAX_ITER  = 1000,
   parameter int ITER_W    = 10,
   parameter int COL_W     = 10,
   parameter int ROW_W     = 9,
   parameter int START_COL = 0,
   parameter int END_COL   = 319,
   parameter int START_ROW = 0,
   parameter int END_ROW   = 479,
   parameter int COLOR_W   = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 start_i,
   input  logic                                 mode_i,
   input  logic signed [INT_BITS+FRAC_BITS-1:0] c_real_i,
   input  logic signed [INT_BITS+FRAC_BITS-1:0] c_imag_i,
   input  logic signed [INT_BITS+FRAC_BITS-1:0] x_min_i,
   input  logic signed [INT_BITS+FRAC_BITS-1:0] y_min_i,
   input  logic signed [INT_BITS+FRAC_BITS-1:0] step_i,
   output logic                                 wr_valid_o,
   input  logic                                 wr_ready_i,
   output logic [COL_W+ROW_W-1:0]               wr_addr_o,
   output logic [COLOR_W-1:0]                   wr_data_o,
   output logic                                 busy_o,
   output logic                                 done_o
);
   localparam int W     = INT_BITS + FRAC_BITS;
   localparam int P     = 2 * W;
   localparam int CLAMP = (1 << COLOR_W) - 2;
   localparam logic [ITER_W-1:0] MAX_I  = ITER_W'(MAX_ITER);
   localparam logic [COL_W-1:0]  SCOL   = COL_W'(START_COL);
   localparam logic [COL_W-1:0]  ECOL   = COL_W'(END_COL);
   localparam logic [ROW_W-1:0]  SROW   = ROW_W'(START_ROW);
   localparam logic [ROW_W-1:0]  EROW   = ROW_W'(END_ROW);
   // 4.0 at product scale (2*FRAC_BITS fraction bits)
   localparam logic [P:0] FOUR = {{(P-2*FRAC_BITS-2){1'b0}}, 1'b1, {(2*FRAC_BITS+2){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_EMIT, S_DONE} state_t;

   typedef struct packed {
      logic                mode;
      logic signed [W-1:0] jcr;
      logic signed [W-1:0] jci;
      logic signed [W-1:0] xmin;
      logic signed [W-1:0] ymin;
      logic signed [W-1:0] step;
   } cfg_t;

   state_t               state_q, state_d;
   cfg_t                 cfg_q, cfg_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic signed [W-1:0]  zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
   logic [ITER_W-1:0]    it_q, it_d;
   logic                 wv_q, wv_d;
   logic [COL_W+ROW_W-1:0] wa_q, wa_d;
   logic [COLOR_W-1:0]   wd_q, wd_d;

   logic signed [P-1:0]  stepx, px, py, zrx, zix, rr, ii, ri;
   logic signed [W-1:0]  pr, pi, zr_n, zi_n;
   logic [P:0]           mag;
   logic                 escaped, accept;

   function automatic logic [COLOR_W-1:0] colour_of(input logic [ITER_W-1:0] n);
      int lg;
      lg = 0;
      for (int b = 0; b < ITER_W; b++) if (n[b]) lg = b;
      if (n == MAX_I)    return '1;
      if (n == '0)       return '0;
      if (lg + 1 > CLAMP) return COLOR_W'(CLAMP);
      return COLOR_W'(lg + 1);
   endfunction

   // Pixel coordinate: frame column/row times step, back to FRAC_BITS scale
   assign stepx = $signed({{W{cfg_q.step[W-1]}}, cfg_q.step});
   assign px    = $signed({{(P-COL_W){1'b0}}, col_q}) * stepx;
   assign py    = $signed({{(P-ROW_W){1'b0}}, row_q}) * stepx;
   assign pr    = cfg_q.xmin + W'(px >>> FRAC_BITS);
   assign pi    = cfg_q.ymin + W'(py >>> FRAC_BITS);

   assign zrx     = $signed({{W{zr_q[W-1]}}, zr_q});
   assign zix     = $signed({{W{zi_q[W-1]}}, zi_q});
   assign rr      = zrx * zrx;
   assign ii      = zix * zix;
   assign ri      = zrx * zix;
   assign mag     = {1'b0, rr} + {1'b0, ii};
   assign escaped = (mag >= FOUR);
   // 2*zr*zi folded into a shift one bit shorter
   assign zr_n    = W'((rr - ii) >>> FRAC_BITS) + cr_q;
   assign zi_n    = W'(ri >>> (FRAC_BITS - 1)) + ci_q;
   assign accept  = wv_q & wr_ready_i;

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      col_d   = col_q;
      row_d   = row_q;
      zr_d    = zr_q;
      zi_d    = zi_q;
      cr_d    = cr_q;
      ci_d    = ci_q;
      it_d    = it_q;
      wv_d    = wv_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      case (state_q)
         S_INIT: begin
            zr_d    = cfg_q.mode ? '0 : pr;
            zi_d    = cfg_q.mode ? '0 : pi;
            cr_d    = cfg_q.mode ? pr : cfg_q.jcr;
            ci_d    = cfg_q.mode ? pi : cfg_q.jci;
            it_d    = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (!escaped && it_q < MAX_I) begin
               zr_d = zr_n;
               zi_d = zi_n;
               it_d = it_q + 1'b1;
            end else begin
               wv_d    = 1'b1;
               wa_d    = {col_q, row_q};
               wd_d    = colour_of(it_q);
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (accept) begin
               wv_d = 1'b0;
               if (col_q == ECOL) begin
                  col_d = SCOL;
                  if (row_q == EROW) begin
                     row_d   = SROW;
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = S_INIT;
                  end
               end else begin
                  col_d   = col_q + 1'b1;
                  state_d = S_INIT;
               end
            end
         end
         default: ;
      endcase
      // restart wins over everything, including a write still waiting for ready
      if (start_i) begin
         cfg_d   = '{mode: mode_i, jcr: c_real_i, jci: c_imag_i,
                     xmin: x_min_i, ymin: y_min_i, step: step_i};
         col_d   = SCOL;
         row_d   = SROW;
         wv_d    = 1'b0;
         state_d = S_INIT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cfg_q   <= '0;
         col_q   <= SCOL;
         row_q   <= SROW;
         zr_q    <= '0;
         zi_q    <= '0;
         cr_q    <= '0;
         ci_q    <= '0;
         it_q    <= '0;
         wv_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         col_q   <= col_d;
         row_q   <= row_d;
         zr_q    <= zr_d;
         zi_q    <= zi_d;
         cr_q    <= cr_d;
         ci_q    <= ci_d;
         it_q    <= it_d;
         wv_q    <= wv_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
      end
   end

   assign wr_valid_o = wv_q;
   assign wr_addr_o  = wa_q;
   assign wr_data_o  = wd_q;
   assign busy_o     = (state_q == S_INIT) || (state_q == S_ITER) || (state_q == S_EMIT);
   assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_julia_stripe_engine.sv
// Bench for julia_stripe_engine: escape-time reference model, per-cycle write monitor,
// directed scenarios (interior/escape pixels, stalls, async reset, restart) and random configs.
module tb_julia_stripe_engine;
   localparam int INT = 4, FR = 33, W = INT + FR, MAXI = 1000, IW = 10;
   localparam int CW = 10, RW = 9, CLW = 4;
   localparam int SC = 3, EC = 5, SR = 2, ER = 3;
   localparam int NPIX = (EC - SC + 1) * (ER - SR + 1);
   localparam logic [2*W:0] FOUR = (2*W+1)'(1) << (2*FR + 2);

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, wr_ready = 1'b0;
   logic signed [W-1:0] c_re = '0, c_im = '0, xm = '0, ym = '0, st = '0;
   logic wr_valid, busy, done;
   logic [CW+RW-1:0] wr_addr;
   logic [CLW-1:0] wr_data;

   julia_stripe_engine #(.INT_BITS(INT), .FRAC_BITS(FR), .MAX_ITER(MAXI), .ITER_W(IW),
      .COL_W(CW), .ROW_W(RW), .START_COL(SC), .END_COL(EC), .START_ROW(SR), .END_ROW(ER),
      .COLOR_W(CLW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
      .c_real_i(c_re), .c_imag_i(c_im), .x_min_i(xm), .y_min_i(ym), .step_i(st),
      .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .busy_o(busy), .done_o(done));

   always #5 clk = ~clk;

   int total = 0, bad = 0, accepted = 0;

   typedef struct { logic [CW+RW-1:0] addr; logic [CLW-1:0] data; int lat; } exp_t;
   exp_t q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // number of iterations before escape, straight from the fixed-point rules
   function automatic int ref_iter(input bit md, input logic signed [W-1:0] cre, cim, x0, y0, s,
                                   input int col, row);
      logic signed [2*W-1:0] a, rr, ii, ri;
      logic signed [W-1:0] pr, pi, zr, zi, kr, ki, t;
      logic [2*W:0] mag;
      int n;
      a  = (2*W)'(col) * (2*W)'(s);
      pr = x0 + W'(a >>> FR);
      a  = (2*W)'(row) * (2*W)'(s);
      pi = y0 + W'(a >>> FR);
      if (md) begin zr = '0; zi = '0; kr = pr; ki = pi; end
      else    begin zr = pr; zi = pi; kr = cre; ki = cim; end
      n = 0;
      while (1'b1) begin
         rr  = (2*W)'(zr) * (2*W)'(zr);
         ii  = (2*W)'(zi) * (2*W)'(zi);
         ri  = (2*W)'(zr) * (2*W)'(zi);
         mag = (2*W+1)'(rr) + (2*W+1)'(ii);
         if (mag >= FOUR || n >= MAXI) return n;
         t  = W'((rr - ii) >>> FR) + kr;
         zi = W'(ri >>> (FR - 1)) + ki;
         zr = t;
         n++;
      end
      return n;
   endfunction

   function automatic int ref_col(input int n);
      if (n >= MAXI) return (1 << CLW) - 1;
      if (n == 0) return 0;
      return ($clog2(n + 1) > (1 << CLW) - 2) ? (1 << CLW) - 2 : $clog2(n + 1);
   endfunction

   function automatic logic signed [W-1:0] fx(input int k); // k in units of 2^-10
      longint v;
      v = longint'(k) <<< (FR - 10);
      return W'(v);
   endfunction

   function automatic logic signed [W-1:0] rfx(input int lo, input int hi);
      return fx(lo + int'($urandom_range(0, hi - lo)));
   endfunction

   // Write monitor: content, latency (idle cycles since start/accept) and hold-while-stalled
   logic pv = 1'b0, pacc = 1'b0;
   logic [CW+RW-1:0] pa;
   logic [CLW-1:0] pd;
   int gap = 0;
   always @(negedge clk) begin
      if (!rst_n || start) begin
         pv = 1'b0; pacc = 1'b0; gap = 0;
      end else begin
         if (wr_valid) begin
            if (!pv || pacc) begin
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_write actual=%0h required=no write", wr_addr);
               end else begin
                  chk("wr_addr", 64'(wr_addr), 64'(q[0].addr));
                  chk("wr_data", 64'(wr_data), 64'(q[0].data));
                  chk("latency", 64'(gap), 64'(q[0].lat));
               end
            end else begin
               chk("hold_addr", 64'(wr_addr), 64'(pa));
               chk("hold_data", 64'(wr_data), 64'(pd));
            end
            pa = wr_addr; pd = wr_data; pacc = wr_ready;
            if (wr_ready) begin
               if (q.size() > 0) void'(q.pop_front());
               accepted++;
               gap = 0;
            end
         end else begin
            gap++;
            pacc = 1'b0;
         end
         pv = wr_valid;
      end
   end

   task automatic do_start(input bit md, input logic signed [W-1:0] cre, cim, x0, y0, s);
      int n;
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1; mode = md; c_re = cre; c_im = cim; xm = x0; ym = y0; st = s;
      wr_ready = 1'b0;
      q.delete();
      accepted = 0;
      for (int r = SR; r <= ER; r++)
         for (int c = SC; c <= EC; c++) begin
            n = ref_iter(md, cre, cim, x0, y0, s, c, r);
            e.addr = {CW'(c), RW'(r)};
            e.data = CLW'(ref_col(n));
            e.lat  = n + 2;
            q.push_back(e);
         end
      @(posedge clk); #1;
      start = 1'b0;
      // config must be ignored outside the start cycle
      mode = ~md; c_re = W'({$urandom, $urandom}); xm = W'({$urandom, $urandom}); st = W'($urandom);
      @(negedge clk);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("done_after_start", 64'(done), 64'd0);
      chk("valid_after_start", 64'(wr_valid), 64'd0);
   endtask

   task automatic run_to_done(input int rdy_pct);
      int budget;
      budget = 20000;
      while (q.size() > 0 && budget > 0) begin
         wr_ready = ($urandom_range(0, 99) < rdy_pct);
         @(posedge clk); #1;
         budget--;
      end
      wr_ready = 1'b0;
      if (budget == 0) begin
         total++; bad++;
         $display("FAIL stripe_timeout actual=%0d pending required=0", q.size());
      end
      @(negedge clk);
      chk("done_set", 64'(done), 64'd1);
      chk("busy_clr", 64'(busy), 64'd0);
      chk("write_count", 64'(accepted), 64'(NPIX));
      repeat (3) @(negedge clk);
      chk("done_held", 64'(done), 64'd1);
      chk("no_valid_in_done", 64'(wr_valid), 64'd0);
   endtask

   task automatic wait_valid();
      int b;
      b = 5000;
      while (!wr_valid && b > 0) begin @(negedge clk); b--; end
      if (b == 0) begin
         total++; bad++;
         $display("FAIL wait_valid_timeout actual=0 required=1");
      end
   endtask

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_valid", 64'(wr_valid), 64'd0);
      chk("rst_addr", 64'(wr_addr), 64'd0);
      chk("rst_data", 64'(wr_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // hand-computed pins of the model
      chk("pin_mand_origin", 64'(ref_iter(1'b1, '0, '0, '0, '0, '0, 0, 0)), 64'd1000);
      chk("pin_mand_two", 64'(ref_iter(1'b1, '0, '0, fx(2048), '0, '0, 0, 0)), 64'd1);
      chk("pin_mand_one", 64'(ref_iter(1'b1, '0, '0, fx(1024), '0, '0, 0, 0)), 64'd2);
      chk("pin_julia_half", 64'(ref_iter(1'b0, '0, '0, fx(512), '0, '0, 0, 0)), 64'd1000);
      chk("pin_col_max", 64'(ref_col(1000)), 64'd15);
      chk("pin_col_0", 64'(ref_col(0)), 64'd0);
      chk("pin_col_5", 64'(ref_col(5)), 64'd3);
      chk("pin_col_600", 64'(ref_col(600)), 64'd10);

      // interior pixels: ITER runs the full 1001 cycles
      do_start(1'b1, '0, '0, '0, '0, '0);
      chk("t1_first_lat", 64'(q[0].lat), 64'd1002);
      chk("t1_first_data", 64'(q[0].data), 64'd15);
      run_to_done(100);

      // single-iteration escape, Julia interior
      do_start(1'b1, '0, '0, fx(2048), '0, '0);
      run_to_done(100);
      do_start(1'b0, '0, '0, fx(512), '0, '0);
      run_to_done(100);

      // raster order with ready always high
      do_start(1'b1, '0, '0, fx(-2048), fx(-1024), fx(200));
      run_to_done(100);

      // five-cycle stall on the first write
      do_start(1'b1, '0, '0, fx(2048), '0, '0);
      wait_valid();
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", 64'(wr_valid), 64'd1);
         chk("stall_no_accept", 64'(accepted), 64'd0);
         chk("stall_addr", 64'(wr_addr), 64'({CW'(SC), RW'(SR)}));
      end
      run_to_done(100);

      // async reset between edges while the second pixel iterates
      do_start(1'b1, '0, '0, '0, '0, '0);
      begin
         int b;
         b = 3000;
         wr_ready = 1'b1;
         while (accepted < 1 && b > 0) begin @(posedge clk); #1; b--; end
         wr_ready = 1'b0;
         if (b == 0) begin
            total++; bad++;
            $display("FAIL reset_setup_timeout actual=0 required=1");
         end
      end
      repeat (100) @(posedge clk);
      #3 rst_n = 1'b0;
      q.delete();
      #1;
      chk("areset_valid", 64'(wr_valid), 64'd0);
      chk("areset_addr", 64'(wr_addr), 64'd0);
      chk("areset_data", 64'(wr_data), 64'd0);
      chk("areset_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      wr_ready = 1'b1;
      repeat (40) begin
         @(negedge clk);
         chk("idle_no_write", 64'(wr_valid), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
      end
      wr_ready = 1'b0;

      // restart while a write is pending
      do_start(1'b1, '0, '0, fx(2048), '0, '0);
      wait_valid();
      do_start(1'b1, '0, '0, fx(1024), '0, '0);
      chk("restart_first_data", 64'(q[0].data), 64'd2);
      run_to_done(70);

      // randomized configs, one with fully random (wrapping) values
      for (int k = 0; k < 6; k++) begin
         if (k == 5)
            do_start($urandom_range(0, 1) == 1, W'({$urandom, $urandom}), W'({$urandom, $urandom}),
                     W'({$urandom, $urandom}), W'({$urandom, $urandom}), W'({$urandom, $urandom}));
         else
            do_start($urandom_range(0, 1) == 1, rfx(-1536, 1536), rfx(-1536, 1536),
                     rfx(-2560, 1024), rfx(-1536, 1536), rfx(0, 256));
         run_to_done(int'($urandom_range(30, 100)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
